sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
// Shares the single SDRAM master port of the Bayer-filter custom logic between two requesters.
// - Read client: window-buffer pixel fetch.
// - Write client: filtered-pixel writeback.
// Round-robin arbitration; at most one SDRAM transaction in flight at any time.
// A read timeout guards against a lost sdram_datareadvalid.
// Sits between the filter control FSM and the top-level sdram_* pins.
// PARAMETERS
// ADDR_W      26   SDRAM word address width
// DATA_W      32   SDRAM data width (A,R,G,B bytes)
// RD_TIMEOUT  255  max cycles in RD_WAIT before abort; counter width = $clog2(RD_TIMEOUT+1)
// PORTS
// clk                  in   1       system clock, rising edge
// n_rst                in   1       asynchronous reset, active-low
// rd_req               in   1       read request; hold with rd_addr until rd_grant
// rd_addr              in   ADDR_W  read word address
// rd_grant             out  1       1-cycle pulse: read command accepted by SDRAM
// rd_data              out  DATA_W  returned read data, valid when rd_valid
// rd_valid             out  1       1-cycle pulse, registered copy of returned data
// wr_req               in   1       write request; hold with wr_addr/wr_data until wr_grant
// wr_addr              in   ADDR_W  write word address
// wr_data              in   DATA_W  write data
// wr_grant             out  1       1-cycle pulse: write command accepted by SDRAM
// sdram_read_en        out  1       SDRAM read command
// sdram_write_en       out  1       SDRAM write command
// address_sdram        out  ADDR_W  SDRAM address
// writeData_sdram      out  DATA_W  SDRAM write data
// data_sdram           in   DATA_W  SDRAM read data
// sdram_datareadvalid  in   1       data_sdram valid this cycle
// sdram_waitrequest    in   1       SDRAM stalls current command while high
// busy                 out  1       state != IDLE
// rd_timeout_err       out  1       sticky: a read timed out; cleared only by reset
// BEHAVIOUR
// Reset (n_rst low, async):
// - all outputs 0; state=IDLE; last=WR (so read wins the first tie); timeout count 0.
// States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
// IDLE:
// - rd_req only -> RD_ISSUE; latch rd_addr into address_sdram.
// - wr_req only -> WR_ISSUE; latch wr_addr into address_sdram and wr_data into writeData_sdram.
// - both requests -> grant the client opposite to last; update last on each grant.
// - Latency: request seen in IDLE at edge N -> command driven from edge N+1.
// RD_ISSUE:
// - sdram_read_en=1; address held stable.
// - Cycle with sdram_waitrequest=0 is acceptance: rd_grant=1 that cycle; next state RD_WAIT.
// RD_WAIT:
// - sdram_read_en=0; count cycles.
// - On sdram_datareadvalid: rd_data<=data_sdram, rd_valid=1 next cycle; -> IDLE.
// - Count reaches RD_TIMEOUT with no data: rd_timeout_err<=1; no rd_valid; -> IDLE.
// - Count clears on leaving RD_WAIT.
// WR_ISSUE:
// - sdram_write_en=1; address and data held stable.
// - Acceptance when sdram_waitrequest=0: wr_grant=1; -> IDLE. Writes need no completion wait.
// Command rules:
// - read_en and write_en never both 1.
// - Commands are 1 cycle long when waitrequest=0; stretched while waitrequest=1.
// Edge cases:
// - sdram_datareadvalid outside RD_WAIT is ignored: no rd_valid, no state change.
// - A request still high in the cycle after its grant is treated as a new request.
// - Requests arriving during busy wait; no queuing beyond the request level.
// - address_sdram / writeData_sdram keep their last value in IDLE; only the *_en strobes qualify them.
// - Reset mid-transaction aborts it immediately, with no grant or valid pulse.
// TESTING
// 1. rd_req, rd_addr=0x0000010, waitrequest=0, datareadvalid 2 cycles later with 0xFF102030
//    -> read_en high 1 cycle at 0x0000010; rd_grant in the same cycle; rd_valid 1 cycle after, rd_data=0xFF102030.
// 2. After reset, rd_req and wr_req together -> read served first, then write.
//    Second simultaneous pair -> write first (alternation).
// 3. Write 0x00AABBCC to 0x0000100 with waitrequest high for 3 cycles
//    -> write_en, address and data stable 4 cycles; wr_grant only in the 4th.
// 4. Read with no datareadvalid for 255 cycles -> rd_timeout_err=1, busy=0;
//    a following write issues normally and err stays 1.
// 5. n_rst low during RD_WAIT -> all outputs 0 at once; datareadvalid after reset release -> no rd_valid.
// 6. Stray datareadvalid in IDLE -> rd_valid stays 0; state stays IDLE.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM master port between a pixel-fetch read client and a
// filtered-pixel writeback client. Round-robin on ties, one transaction in
// flight at a time, and a read timeout that recovers from a lost
// sdram_datareadvalid by returning to IDLE and raising a sticky error flag.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  // read client
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  // write client
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  // SDRAM master port
  output logic              sdram_read_en,
  output logic              sdram_write_en,
  output logic [ADDR_W-1:0] address_sdram,
  output logic [DATA_W-1:0] writeData_sdram,
  input  logic [DATA_W-1:0] data_sdram,
  input  logic              sdram_datareadvalid,
  input  logic              sdram_waitrequest,
  // status
  output logic              busy,
  output logic              rd_timeout_err
);

  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  // Last cycle of the wait window: RD_WAIT lasts at most RD_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_ISSUE = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_WR_ISSUE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_wr;   // 1: write was granted most recently
  logic [CNT_W-1:0] r_cnt;
  logic             w_pick_rd;
  logic             w_pick_wr;
  logic             w_rd_done;
  logic             w_timeout;

  // Data return and timeout are only meaningful while waiting on a read;
  // a data beat in the final window cycle wins over the timeout.
  assign w_rd_done = (r_state == S_RD_WAIT) && sdram_datareadvalid;
  assign w_timeout = (r_state == S_RD_WAIT) && !sdram_datareadvalid &&
                     (r_cnt == CNT_LAST);

  // Command strobes and grants decode straight from the state register so
  // they are 0 the moment reset asserts; grants mark the accepting cycle.
  assign sdram_read_en  = (r_state == S_RD_ISSUE);
  assign sdram_write_en = (r_state == S_WR_ISSUE);
  assign rd_grant       = (r_state == S_RD_ISSUE) && !sdram_waitrequest;
  assign wr_grant       = (r_state == S_WR_ISSUE) && !sdram_waitrequest;
  assign busy           = (r_state != S_IDLE);

  // Next-state and arbitration decision
  always_comb begin
    w_next    = r_state;
    w_pick_rd = 1'b0;
    w_pick_wr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Read wins unless both are pending and read went last.
        if (rd_req && (!wr_req || r_last_wr)) begin
          w_pick_rd = 1'b1;
          w_next    = S_RD_ISSUE;
        end else if (wr_req) begin
          w_pick_wr = 1'b1;
          w_next    = S_WR_ISSUE;
        end
      end
      S_RD_ISSUE: if (!sdram_waitrequest) w_next = S_RD_WAIT;
      S_RD_WAIT:  if (w_rd_done || w_timeout) w_next = S_IDLE;
      S_WR_ISSUE: if (!sdram_waitrequest) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State register and round-robin history
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_last_wr <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_pick_rd) r_last_wr <= 1'b0;
      if (w_pick_wr) r_last_wr <= 1'b1;
    end
  end

  // Command address/data capture; held through stalls and left as-is in IDLE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      address_sdram   <= '0;
      writeData_sdram <= '0;
    end else if (w_pick_rd) begin
      address_sdram   <= rd_addr;
    end else if (w_pick_wr) begin
      address_sdram   <= wr_addr;
      writeData_sdram <= wr_data;
    end
  end

  // Read-wait cycle counter, cleared whenever RD_WAIT is not continuing
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_RD_WAIT) && (w_next == S_RD_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered read return; stray data beats outside RD_WAIT are dropped
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= w_rd_done;
      if (w_rd_done) rd_data <= data_sdram;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      rd_timeout_err <= 1'b1;
    end
  end

endmodule
